// File: rtl/uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : uart_receiver                                                    |
// | Brief   : 16x-oversampled UART receiver with valid/ack byte handoff.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop2_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_tcnt;
  logic [2:0]             r_bcnt;
  logic [7:0]             r_shift;
  logic [1:0]             r_nbits;
  logic                   r_pen;
  logic                   r_podd;
  logic                   r_stop2;
  logic                   r_stop_second;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_done;

  logic w_rx_s;
  logic w_mid_start;
  logic w_mid_bit;
  logic w_last_bit;
  logic w_final_stop;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
  end

  assign w_rx_s       = r_sync[SYNC_STAGES-1];
  assign w_mid_start  = ov_baud_rt_i && (r_tcnt == 4'd7);
  assign w_mid_bit    = ov_baud_rt_i && (r_tcnt == 4'd15);
  assign w_last_bit   = (r_bcnt == ({1'b0, r_nbits} + 3'd4));
  assign w_final_stop = (r_state == S_STOP) && w_mid_bit && (!r_stop2 || r_stop_second);
  assign busy_o       = (r_state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ov_baud_rt_i && !w_rx_s) w_next = S_START;
      S_START:  if (w_mid_start) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_mid_bit && w_last_bit) w_next = r_pen ? S_PARITY : S_STOP;
      S_PARITY: if (w_mid_bit) w_next = S_STOP;
      S_STOP:   if (w_final_stop) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tcnt        <= 4'd0;
      r_bcnt        <= 3'd0;
      r_shift       <= 8'd0;
      r_nbits       <= 2'd0;
      r_pen         <= 1'b0;
      r_podd        <= 1'b0;
      r_stop2       <= 1'b0;
      r_stop_second <= 1'b0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_final_stop;
      case (r_state)
        S_IDLE: begin
          if (ov_baud_rt_i && !w_rx_s) r_tcnt <= 4'd0;
        end
        S_START: begin
          if (w_mid_start) begin
            r_tcnt <= 4'd0;
            if (!w_rx_s) begin
              r_bcnt        <= 3'd0;
              r_shift       <= 8'd0;
              r_nbits       <= data_bits_i;
              r_pen         <= parity_en_i;
              r_podd        <= parity_odd_i;
              r_stop2       <= stop2_i;
              r_stop_second <= 1'b0;
              r_perr        <= 1'b0;
              r_ferr        <= 1'b0;
            end
          end else if (ov_baud_rt_i) begin
            r_tcnt <= r_tcnt + 4'd1;
          end
        end
        S_DATA: begin
          if (ov_baud_rt_i) r_tcnt <= r_tcnt + 4'd1;
          if (w_mid_bit) begin
            r_shift[r_bcnt] <= w_rx_s;
            if (!w_last_bit) r_bcnt <= r_bcnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (ov_baud_rt_i) r_tcnt <= r_tcnt + 4'd1;
          // Unused upper shift bits are zero, so they do not disturb the XOR.
          if (w_mid_bit) r_perr <= (w_rx_s != (^r_shift ^ r_podd));
        end
        S_STOP: begin
          if (ov_baud_rt_i) r_tcnt <= r_tcnt + 4'd1;
          if (w_mid_bit) begin
            if (!w_rx_s) r_ferr <= 1'b1;
            r_stop_second <= 1'b1;
          end
        end
        default: r_tcnt <= 4'd0;
      endcase
    end
  end

  // A completing frame takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_o     <= 8'd0;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else if (r_done) begin
      rx_data_o     <= r_shift;
      rx_valid_o    <= 1'b1;
      parity_err_o  <= r_perr;
      frame_err_o   <= r_ferr;
      overrun_err_o <= rx_valid_o && !rx_ack_i;
    end else if (rx_ack_i && rx_valid_o) begin
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for uart_receiver: serial frames driven on rx_i, parallel
// results compared against hand-computed values with immediate assertions.
module tb_uart_receiver;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       ov_baud_rt_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [1:0] data_bits_i = 2'b11;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       stop2_i = 1'b0;
  logic       rx_ack_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 4;
  int tick_cnt = 0;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ov_baud_rt_i  (ov_baud_rt_i),
    .rx_i          (rx_i),
    .data_bits_i   (data_bits_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .rx_ack_i      (rx_ack_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversampling tick: one clock wide, every tick_div clocks.
  always @(negedge clk_i) begin
    if (tick_cnt >= tick_div - 1) begin
      ov_baud_rt_i = 1'b1;
      tick_cnt = 0;
    end else begin
      ov_baud_rt_i = 1'b0;
      tick_cnt++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    rx_i = b;
    repeat (16 * tick_div) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input bit par_bit, input bit stop_a, input bit has_stop_b,
                            input bit stop_b);
    bit_time(1'b0);
    for (int i = 0; i < nbits; i++) bit_time(data[i]);
    if (has_par) bit_time(par_bit);
    bit_time(stop_a);
    if (has_stop_b) bit_time(stop_b);
    rx_i = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack_i = 1'b1;
    @(negedge clk_i);
    rx_ack_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy_o !== 1'b0 && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    check(tag, {7'd0, busy_o}, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_data",  rx_data_o, 8'h00);
    check("rst_valid", {7'd0, rx_valid_o}, 8'd0);
    check("rst_busy",  {7'd0, busy_o}, 8'd0);
    check("rst_errs",  {5'd0, parity_err_o, frame_err_o, overrun_err_o}, 8'd0);
    rst_n_i = 1'b1;
    repeat (8) @(negedge clk_i);

    // 1. 8N1 0xA5
    send_frame(8'hA5, 8, 0, 0, 1, 0, 0);
    check("t1_data",  rx_data_o, 8'hA5);
    check("t1_valid", {7'd0, rx_valid_o}, 8'd1);
    check("t1_errs",  {5'd0, parity_err_o, frame_err_o, overrun_err_o}, 8'd0);
    pulse_ack();
    check("t1_ack_valid", {7'd0, rx_valid_o}, 8'd0);
    check("t1_ack_hold",  rx_data_o, 8'hA5);

    // 2. Start glitch of 5 ticks
    rx_i = 1'b0;
    repeat (5 * tick_div) @(negedge clk_i);
    check("t2_busy_glitch", {7'd0, busy_o}, 8'd1);
    rx_i = 1'b1;
    repeat (32 * tick_div) @(negedge clk_i);
    check("t2_busy_after",  {7'd0, busy_o}, 8'd0);
    check("t2_no_valid",    {7'd0, rx_valid_o}, 8'd0);

    // 3. 8E1 0x3C: four ones, correct even parity bit is 0
    parity_en_i = 1'b1;
    parity_odd_i = 1'b0;
    send_frame(8'h3C, 8, 1, 1, 1, 0, 0);
    check("t3_data_bad", rx_data_o, 8'h3C);
    check("t3_perr_bad", {7'd0, parity_err_o}, 8'd1);
    check("t3_ferr_bad", {7'd0, frame_err_o}, 8'd0);
    pulse_ack();
    send_frame(8'h3C, 8, 1, 0, 1, 0, 0);
    check("t3_perr_ok",  {7'd0, parity_err_o}, 8'd0);
    check("t3_valid_ok", {6'd0, rx_valid_o, overrun_err_o}, 8'b10);
    pulse_ack();

    // 4. 8N2 0x81 with second stop low
    parity_en_i = 1'b0;
    stop2_i = 1'b1;
    send_frame(8'h81, 8, 0, 0, 1, 1, 0);
    check("t4_data", rx_data_o, 8'h81);
    check("t4_ferr", {6'd0, frame_err_o, parity_err_o}, 8'b10);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    stop2_i = 1'b0;
    repeat (32 * tick_div) @(negedge clk_i);

    // 5. Overrun, then completion coinciding with acknowledge
    send_frame(8'h11, 8, 0, 0, 1, 0, 0);
    check("t5_first", rx_data_o, 8'h11);
    send_frame(8'h22, 8, 0, 0, 1, 0, 0);
    check("t5_ovr_data",  rx_data_o, 8'h22);
    check("t5_ovr_flag",  {6'd0, rx_valid_o, overrun_err_o}, 8'b11);
    pulse_ack();
    check("t5_ovr_clear", {6'd0, rx_valid_o, overrun_err_o}, 8'b00);
    send_frame(8'h11, 8, 0, 0, 1, 0, 0);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(1'(8'h22 >> i));
    rx_i = 1'b1;
    wait_idle("t5_busy_drop", 32 * tick_div);
    pulse_ack();
    check("t5_ack_data",  rx_data_o, 8'h22);
    check("t5_ack_flags", {6'd0, rx_valid_o, overrun_err_o}, 8'b10);
    repeat (16 * tick_div) @(negedge clk_i);
    pulse_ack();

    // 6. 5O1 0x15 with a tick every clock; three ones, so odd parity bit is 0
    tick_div = 1;
    data_bits_i = 2'b00;
    parity_en_i = 1'b1;
    parity_odd_i = 1'b1;
    repeat (16) @(negedge clk_i);
    send_frame(8'h15, 5, 1, 0, 1, 0, 0);
    check("t6_data", rx_data_o, 8'h15);
    check("t6_flags", {4'd0, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o}, 8'b1000);
    pulse_ack();
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("t6_busy_mid", {7'd0, busy_o}, 8'd1);
    rst_n_i = 1'b0;
    #1;
    check("t6_rst_data", rx_data_o, 8'h00);
    check("t6_rst_outs", {3'd0, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o}, 8'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (64) @(negedge clk_i);
    check("t6_no_frame", {6'd0, rx_valid_o, busy_o}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
